serial_word_adapter: RTL and testbench
======================================

Name: serial_word_adapter

Overview:
Parallel-to-serial front end for the bit-serial stack register cell. Accepts whole words from the datapath over a valid/ready handshake and shifts them into the cell, one bit per clock, using the cell's din/write pins. On request, it pulses the cell's read pin, collects the bit stream on dout back into a parallel word, and returns it with a one-cycle valid strobe. It performs one operation at a time, so the cell never sees an overlapping read and write.

Parameters:
SIZE, 4, bits per word; must match the attached serial cell; minimum 2
READ_LAT, 1, cycles from the ser_read pulse to bit 0 appearing on ser_dout; 0 is legal

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
wr_valid  input  1  write word offered
wr_ready  output  1  adapter idle; write accepted on wr_valid & wr_ready at the edge
wr_data  input  SIZE  word to store
rd_req  input  1  read request; level, sampled only when idle
rd_valid  output  1  one-cycle strobe; rd_data is the new word
rd_data  output  SIZE  last word read; held until the next rd_valid
busy  output  1  not idle (equals ~wr_ready)
ser_din  output  1  bit to the cell
ser_write  output  1  write enable to the cell
ser_read  output  1  read start pulse to the cell
ser_dout  input  1  bit stream from the cell

Behaviour:
- All outputs are registered. Reset gives: state IDLE, wr_ready=1, busy=0, rd_valid=0, rd_data=0, ser_din=0, ser_write=0, ser_read=0, counter=0.
- FSM states: IDLE, SHIFT_OUT, READ_WAIT, SHIFT_IN.
- IDLE:
  - If wr_valid=1, accept the write: latch wr_data into a shift register and go to SHIFT_OUT.
  - Else if rd_req=1, accept the read and go to READ_WAIT.
  - Write wins when both are asserted. rd_req stays pending and is taken in the first idle cycle after the write completes.
- SHIFT_OUT, for a write accepted at edge T:
  - Cycles T+1 .. T+SIZE: ser_write=1, ser_din=bit k during cycle T+1+k (LSB first by default).
  - wr_ready is low during T+1 .. T+SIZE and high again at T+SIZE+1.
  - ser_write=0 and ser_din=0 outside this window.
- READ_WAIT / SHIFT_IN, for a read accepted at edge T:
  - ser_read=1 during cycle T+1 only.
  - Bit k is sampled from ser_dout during cycle T+1+READ_LAT+k, for k = 0..SIZE-1.
  - Bits are assembled in a capture register; bit 0 goes to rd_data[0] by default.
  - rd_data updates and rd_valid=1 in cycle T+1+READ_LAT+SIZE. That cycle is already IDLE, with wr_ready=1.
  - When READ_LAT=0, READ_WAIT is skipped: bit 0 is sampled during the ser_read cycle itself.
- Counter width is $clog2(SIZE+READ_LAT+1). The counter counts down and never wraps; exit happens on 0.
- rd_data is never partially updated: the capture register is separate from rd_data.
- wr_data and wr_valid are ignored while busy. rd_req is ignored while busy; it is not queued beyond the level itself.
- Back-to-back transfers: a new write or read can be accepted in the first IDLE cycle, with no dead cycle between operations.
- Reset mid-operation:
  - The FSM goes to IDLE at that edge, and ser_write/ser_read deassert in the next cycle.
  - An in-flight read produces no rd_valid, and rd_data is cleared to 0.
  - Bits already shifted into the cell stay there; the cell has no reset.

Optional Feature:
Macro SERIAL_ADAPTER_MSB_FIRST_EN.
- Defined: the write shifts MSB first (ser_din during cycle T+1+k is wr_data[SIZE-1-k]), and read bit k lands in rd_data[SIZE-1-k].
- Undefined: LSB-first ordering as above.
- Timing, handshake and port list are identical in both builds.

Test Plan:
- Reset then idle (SIZE=4, READ_LAT=1): wr_ready=1, busy=0, all ser_* outputs 0, rd_data=0 for 5 cycles.
- Write 4'b1011 accepted at edge T: ser_write=1 in cycles T+1..T+4, with ser_din sequence 1,1,0,1; wr_ready returns high at T+5.
- Read with a behavioural cell model driving 1,0,0,1 after READ_LAT=1: ser_read pulses at T+1, then at T+6 rd_valid=1 for exactly one cycle and rd_data=4'b1001.
- wr_valid=1 and rd_req=1 in the same idle cycle: write runs first; ser_read pulses at T+6 (the read is accepted at edge T+5).
- rst asserted at T+3 of a read: no rd_valid, rd_data=0, and ser_read stays 0 afterwards.
- Build with SERIAL_ADAPTER_MSB_FIRST_EN, write 4'b1011: ser_din sequence 1,0,1,1; read sequence 1,0,0,1 gives rd_data=4'b1001.

Source files
------------

// File: rtl/serial_word_adapter.sv
// Parallel-to-serial front end for the bit-serial stack register cell.
// Optional macro SERIAL_ADAPTER_MSB_FIRST_EN selects MSB-first bit ordering.
module serial_word_adapter #(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned READ_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_valid_i,
  output logic            wr_ready_o,
  input  logic [SIZE-1:0] wr_data_i,
  input  logic            rd_req_i,
  output logic            rd_valid_o,
  output logic [SIZE-1:0] rd_data_o,
  output logic            busy_o,
  output logic            ser_din_o,
  output logic            ser_write_o,
  output logic            ser_read_o,
  input  logic            ser_dout_i
);

`ifdef SERIAL_ADAPTER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  localparam int unsigned CNT_W     = $clog2(SIZE + READ_LAT + 1);
  localparam int unsigned WAIT_LOAD = (READ_LAT > 0) ? READ_LAT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SHIFT_OUT, READ_WAIT, SHIFT_IN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   sreg_q, sreg_d;
  logic [SIZE-1:0]   cap_q, cap_d;
  logic [SIZE-1:0]   rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;
  logic              ser_din_q, ser_din_d;
  logic              ser_write_q, ser_write_d;
  logic              ser_read_q, ser_read_d;
  logic              cnt_zero;
  logic [SIZE-1:0]   cap_shift;

  assign cnt_zero  = (cnt_q == '0);
  assign cap_shift = MSB_FIRST ? {cap_q[SIZE-2:0], ser_dout_i}
                               : {ser_dout_i, cap_q[SIZE-1:1]};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_valid_i)    state_d = SHIFT_OUT;
        else if (rd_req_i) state_d = (READ_LAT > 0) ? READ_WAIT : SHIFT_IN;
      end
      SHIFT_OUT: if (cnt_zero) state_d = IDLE;
      READ_WAIT: if (cnt_zero) state_d = SHIFT_IN;
      SHIFT_IN:  if (cnt_zero) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output and datapath next values; every output is a register loaded from here
  always_comb begin
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    cap_d       = cap_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    ser_din_d   = 1'b0;
    ser_write_d = 1'b0;
    ser_read_d  = 1'b0;
    wr_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (wr_valid_i) begin
          cnt_d       = CNT_W'(SIZE - 1);
          ser_write_d = 1'b1;
          ser_din_d   = MSB_FIRST ? wr_data_i[SIZE-1] : wr_data_i[0];
          sreg_d      = MSB_FIRST ? {wr_data_i[SIZE-2:0], 1'b0}
                                  : {1'b0, wr_data_i[SIZE-1:1]};
        end else if (rd_req_i) begin
          ser_read_d = 1'b1;
          cnt_d      = (READ_LAT > 0) ? CNT_W'(WAIT_LOAD) : CNT_W'(SIZE - 1);
        end
      end
      SHIFT_OUT: begin
        if (!cnt_zero) begin
          cnt_d       = cnt_q - CNT_W'(1);
          ser_write_d = 1'b1;
          ser_din_d   = MSB_FIRST ? sreg_q[SIZE-1] : sreg_q[0];
          sreg_d      = MSB_FIRST ? {sreg_q[SIZE-2:0], 1'b0}
                                  : {1'b0, sreg_q[SIZE-1:1]};
        end
      end
      READ_WAIT: begin
        cnt_d = cnt_zero ? CNT_W'(SIZE - 1) : cnt_q - CNT_W'(1);
      end
      SHIFT_IN: begin
        cap_d = cap_shift;
        if (cnt_zero) begin
          rd_data_d  = cap_shift;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      sreg_q      <= '0;
      cap_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      ser_din_q   <= 1'b0;
      ser_write_q <= 1'b0;
      ser_read_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      cap_q       <= cap_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      ser_din_q   <= ser_din_d;
      ser_write_q <= ser_write_d;
      ser_read_q  <= ser_read_d;
    end
  end

  assign wr_ready_o  = wr_ready_q;
  assign busy_o      = busy_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign ser_din_o   = ser_din_q;
  assign ser_write_o = ser_write_q;
  assign ser_read_o  = ser_read_q;

endmodule

// File: tb/tb_serial_word_adapter.sv
// Bench for serial_word_adapter: transaction-level timing model plus directed literal checks.
// Honours SERIAL_ADAPTER_MSB_FIRST_EN for bit ordering.
module tb_serial_word_adapter;
  localparam int unsigned SIZE = 4;
  localparam int RL = 1;
`ifdef SERIAL_ADAPTER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  localparam int OP_NONE = 0;
  localparam int OP_WR   = 1;
  localparam int OP_RD   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_valid = 1'b0;
  logic            rd_req = 1'b0;
  logic            ser_dout = 1'b0;
  logic [SIZE-1:0] wr_data = '0;
  logic            wr_ready, rd_valid, busy, ser_din, ser_write, ser_read;
  logic [SIZE-1:0] rd_data;

  int              n_chk = 0;
  int              n_fail = 0;
  bit              chk_en = 1'b0;
  int              e = 0;
  logic [SIZE-1:0] cell_stream = '0;

  always #5 clk = ~clk;

  serial_word_adapter #(.SIZE(SIZE), .READ_LAT(RL)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_req_i(rd_req), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .busy_o(busy), .ser_din_o(ser_din), .ser_write_o(ser_write),
    .ser_read_o(ser_read), .ser_dout_i(ser_dout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) e++;

  // Behavioural cell: after a read pulse, streams cell_stream bit k (time order) READ_LAT+k cycles later
  int cc = 0;
  int rs = -1000;
  always @(posedge clk) begin
    int k;
    #1;
    cc++;
    if (ser_read === 1'b1) rs = cc;
    k = cc - rs - RL;
    ser_dout = (k >= 0 && k < int'(SIZE)) ? cell_stream[k] : 1'b0;
  end

  // Transaction model: one op at a time, outputs derived from cycles since acceptance
  int              m_op = OP_NONE;
  int              t_acc = 0;
  logic [SIZE-1:0] m_data = '0;
  logic [SIZE-1:0] m_stream = '0;
  logic [SIZE-1:0] m_rd = '0;

  always @(negedge clk) begin
    int   d;
    bit   idle;
    logic x_rdy, x_wr, x_din, x_rd, x_val;
    d = e - t_acc;
    x_rdy = 1'b1; x_wr = 1'b0; x_din = 1'b0; x_rd = 1'b0; x_val = 1'b0;
    if (m_op == OP_WR && d < int'(SIZE)) begin
      x_rdy = 1'b0;
      x_wr  = 1'b1;
      x_din = MSB ? m_data[int'(SIZE) - 1 - d] : m_data[d];
    end
    if (m_op == OP_RD) begin
      if (d == 0) x_rd = 1'b1;
      if (d < RL + int'(SIZE)) x_rdy = 1'b0;
      if (d == RL + int'(SIZE)) begin
        x_val = 1'b1;
        for (int k = 0; k < int'(SIZE); k++)
          m_rd[MSB ? int'(SIZE) - 1 - k : k] = m_stream[k];
      end
    end
    if (chk_en) begin
      chk("m_wr_ready",  32'(wr_ready),  32'(x_rdy));
      chk("m_busy",      32'(busy),      32'(!x_rdy));
      chk("m_ser_write", 32'(ser_write), 32'(x_wr));
      chk("m_ser_din",   32'(ser_din),   32'(x_din));
      chk("m_ser_read",  32'(ser_read),  32'(x_rd));
      chk("m_rd_valid",  32'(rd_valid),  32'(x_val));
      chk("m_rd_data",   32'(rd_data),   32'(m_rd));
    end
    idle = (m_op == OP_NONE) || (m_op == OP_WR && d >= int'(SIZE)) ||
           (m_op == OP_RD && d >= RL + int'(SIZE));
    if (rst) begin
      m_op = OP_NONE;
      m_rd = '0;
    end else if (idle) begin
      if (wr_valid) begin
        m_op = OP_WR; t_acc = e + 1; m_data = wr_data;
      end else if (rd_req) begin
        m_op = OP_RD; t_acc = e + 1; m_stream = cell_stream;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SIZE-1:0] seq;
    logic [SIZE-1:0] rdv;
    int vat, vcnt, rat;
    bit bad_val, bad_rd;
    seq = '0; rdv = '0;
    rst = 1'b1;
    step(); step();
    chk_en = 1'b1;
    rst = 1'b0;

    // Idle after reset
    repeat (5) begin
      chk("reset_rd_data", 32'(rd_data), 32'd0);
      chk("reset_wr_ready", 32'(wr_ready), 32'd1);
      step();
    end

    // Single write of 1011
    wr_data = 4'b1011; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    for (int k = 0; k < int'(SIZE); k++) begin
      seq[k] = ser_din;
      chk("wr_ser_write_on", 32'(ser_write), 32'd1);
      chk("wr_ready_low", 32'(wr_ready), 32'd0);
      step();
    end
    chk("wr_ready_back", 32'(wr_ready), 32'd1);
    chk("wr_ser_write_off", 32'(ser_write), 32'd0);
    chk("wr_din_seq", 32'(seq), MSB ? 32'h0000000D : 32'h0000000B);

    // Read: cell streams 1,0,0,1
    cell_stream = 4'b1001; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("rd_ser_read_pulse", 32'(ser_read), 32'd1);
    vat = 0; vcnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) chk("rd_ser_read_drop", 32'(ser_read), 32'd0);
      if (rd_valid) begin vcnt++; vat = i; rdv = rd_data; end
      step();
    end
    chk("rd_valid_cycle", 32'(vat), 32'd6);
    chk("rd_valid_count", 32'(vcnt), 32'd1);
    chk("rd_data_word", 32'(rdv), 32'h00000009);

    // Write and read requested together: write first, read accepted at T+5
    cell_stream = 4'b0011; wr_data = 4'b0110; wr_valid = 1'b1; rd_req = 1'b1;
    step();
    wr_valid = 1'b0;
    rat = 0;
    for (int i = 1; i <= 12; i++) begin
      if (ser_read && rat == 0) rat = i;
      if (i == 6) rd_req = 1'b0;
      step();
    end
    chk("both_read_pulse_cycle", 32'(rat), 32'd6);
    chk("both_rd_data", 32'(rd_data), MSB ? 32'h0000000C : 32'h00000003);

    // Reset in the middle of a read
    cell_stream = 4'b1111; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bad_val = 1'b0; bad_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rd_valid !== 1'b0) bad_val = 1'b1;
      if (ser_read !== 1'b0) bad_rd = 1'b1;
      chk("rst_rd_data_cleared", 32'(rd_data), 32'd0);
      step();
    end
    chk("rst_no_rd_valid", 32'(bad_val), 32'd0);
    chk("rst_no_ser_read", 32'(bad_rd), 32'd0);

    // Back-to-back writes with wr_valid held and data changing while busy
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = SIZE'(i * 5 + 3);
      step();
    end
    wr_valid = 1'b0;
    repeat (6) step();

    // Back-to-back reads with rd_req held
    cell_stream = 4'b0110; rd_req = 1'b1;
    repeat (14) step();
    rd_req = 1'b0;
    repeat (8) step();
    chk("b2b_rd_data", 32'(rd_data), 32'h00000006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
